// File: rtl/ram_sched.sv
// Arbitrates the byte-wide RAM port between fetch and MEM (MEM wins) and splits
// each access into single-byte RAM cycles, assembling reads little-endian.
module ram_sched #(
   parameter int ADDR_WIDTH = 17
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_done_o,
   output logic [31:0] if_data_o,
   input  logic        mem_re_i,
   input  logic        mem_we_i,
   input  logic [31:0] mem_addr_i,
   input  logic [1:0]  mem_len_i,
   input  logic [31:0] mem_wdata_i,
   output logic        mem_done_o,
   output logic [31:0] mem_rdata_o,
   output logic [31:0] ram_addr_o,
   output logic        ram_wr_o,
   output logic [7:0]  ram_wdata_o,
   input  logic [7:0]  ram_rdata_i,
   output logic        busy_o
);

   if (ADDR_WIDTH < 1 || ADDR_WIDTH > 32) begin : g_bad_addr_width
      $error("ram_sched: ADDR_WIDTH must be 1..32");
   end

   typedef enum logic [1:0] {IDLE, RD, WR} state_t;

   state_t      state, state_nxt;
   logic [31:0] base;
   logic [31:0] wdata;
   logic [31:0] asm_q;
   logic [31:0] asm_cap;
   logic [2:0]  n;
   logic [2:0]  cnt;
   logic [2:0]  req_n;
   logic [1:0]  cnt_m1;
   logic        owner_mem;
   logic        grant;
   logic        r_nw;

   // Hold off arbitration in a done cycle so a still-held request is not re-granted.
   assign grant  = (state == IDLE) && !if_done_o && !mem_done_o &&
                   (mem_we_i || mem_re_i || if_req_i);
   assign busy_o = (state != IDLE);
   assign ram_wr_o = ~r_nw;
   assign cnt_m1 = cnt[1:0] - 2'd1;

   always_comb begin
      if (mem_we_i || mem_re_i) begin
         case (mem_len_i)
            2'd0:    req_n = 3'd1;
            2'd1:    req_n = 3'd2;
            default: req_n = 3'd4;
         endcase
      end else begin
         req_n = 3'd4;
      end
   end

   // Byte cnt-1 arrives now, one cycle after its address was driven.
   always_comb begin
      asm_cap = asm_q;
      if (cnt != 3'd0) asm_cap[{cnt_m1, 3'b000} +: 8] = ram_rdata_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      r_nw        = 1'b1;
      ram_addr_o  = 32'd0;
      ram_wdata_o = 8'd0;
      case (state)
         IDLE: begin
            if (grant) state_nxt = mem_we_i ? WR : RD;
         end
         RD: begin
            ram_addr_o = base + 32'(cnt);
            if (cnt == n) state_nxt = IDLE;
         end
         WR: begin
            r_nw        = 1'b0;
            ram_addr_o  = base + 32'(cnt);
            ram_wdata_o = wdata[{cnt[1:0], 3'b000} +: 8];
            if (cnt == n - 3'd1) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base        <= 32'd0;
         wdata       <= 32'd0;
         asm_q       <= 32'd0;
         n           <= 3'd0;
         cnt         <= 3'd0;
         owner_mem   <= 1'b0;
         if_done_o   <= 1'b0;
         if_data_o   <= 32'd0;
         mem_done_o  <= 1'b0;
         mem_rdata_o <= 32'd0;
      end else begin
         if_done_o  <= 1'b0;
         mem_done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (grant) begin
                  owner_mem <= mem_we_i || mem_re_i;
                  base      <= (mem_we_i || mem_re_i) ? mem_addr_i : if_addr_i;
                  wdata     <= mem_wdata_i;
                  n         <= req_n;
                  cnt       <= 3'd0;
                  asm_q     <= 32'd0;
               end
            end
            RD: begin
               asm_q <= asm_cap;
               cnt   <= cnt + 3'd1;
               if (cnt == n) begin
                  if (owner_mem) begin
                     mem_rdata_o <= asm_cap;
                     mem_done_o  <= 1'b1;
                  end else begin
                     if_data_o <= asm_cap;
                     if_done_o <= 1'b1;
                  end
               end
            end
            WR: begin
               cnt <= cnt + 3'd1;
               if (cnt == n - 3'd1) mem_done_o <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_sched.sv
// Self-checking bench for ram_sched with a byte RAM model and a byte-array reference.
module tb_ram_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req_i = 1'b0;
   logic [31:0] if_addr_i = '0;
   logic        if_done_o;
   logic [31:0] if_data_o;
   logic        mem_re_i = 1'b0;
   logic        mem_we_i = 1'b0;
   logic [31:0] mem_addr_i = '0;
   logic [1:0]  mem_len_i = '0;
   logic [31:0] mem_wdata_i = '0;
   logic        mem_done_o;
   logic [31:0] mem_rdata_o;
   logic [31:0] ram_addr_o;
   logic        ram_wr_o;
   logic [7:0]  ram_wdata_o;
   logic [7:0]  ram_rdata_i = '0;
   logic        busy_o;

   ram_sched #(.ADDR_WIDTH(17)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_done_o(if_done_o), .if_data_o(if_data_o),
      .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_len_i(mem_len_i),
      .mem_wdata_i(mem_wdata_i), .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o),
      .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o), .ram_wdata_o(ram_wdata_o),
      .ram_rdata_i(ram_rdata_i), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   // Synchronous-read byte RAM; the preload port lets the bench seed contents.
   logic [7:0]  ram [0:4095] = '{default: 8'h00};
   logic        pl_en = 1'b0;
   logic [11:0] pl_addr = '0;
   logic [7:0]  pl_dat = '0;
   always @(posedge clk) begin
      if (pl_en)         ram[pl_addr] <= pl_dat;
      else if (ram_wr_o) ram[ram_addr_o[11:0]] <= ram_wdata_o;
      ram_rdata_i <= ram[ram_addr_o[11:0]];
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic poke(input logic [11:0] a, input logic [7:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_dat = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   function automatic int nbytes(input int kind, input logic [1:0] len);
      if (kind == 0) return 4;
      case (len)
         2'd0:    return 1;
         2'd1:    return 2;
         default: return 4;
      endcase
   endfunction

   // kind: 0 fetch, 1 load, 2 store, 3 store with mem_re also high.
   task automatic run_txn(input int kind, input logic [31:0] addr, input logic [1:0] len,
                          input logic [31:0] wd, output logic [31:0] data,
                          output int lat, output int wrcyc);
      @(negedge clk);
      if_req_i    = (kind == 0);
      if_addr_i   = addr;
      mem_re_i    = (kind == 1 || kind == 3);
      mem_we_i    = (kind >= 2);
      mem_addr_i  = addr;
      mem_len_i   = len;
      mem_wdata_i = wd;
      lat = -1; wrcyc = 0; data = '0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (ram_wr_o) wrcyc++;
         if ((kind == 0 && if_done_o) || (kind != 0 && mem_done_o)) begin
            lat  = k;
            data = (kind == 0) ? if_data_o : mem_rdata_o;
            break;
         end
      end
      if_req_i = 1'b0; mem_re_i = 1'b0; mem_we_i = 1'b0;
   endtask

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [1:0]  len;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;

   vec_t        tbl [7];
   logic [7:0]  sh [0:4095];
   logic [31:0] got, expd;
   int          lat, wrcyc, n;

   initial begin
      tbl[0] = '{2, 32'h100, 2'd2, 32'h0FF00FF0, 32'h0};
      tbl[1] = '{1, 32'h100, 2'd2, 32'h0,        32'h0FF00FF0};
      tbl[2] = '{1, 32'h101, 2'd0, 32'h0,        32'h0000000F};
      tbl[3] = '{1, 32'h101, 2'd1, 32'h0,        32'h0000F00F};
      tbl[4] = '{3, 32'h1FF, 2'd0, 32'h0000005A, 32'h0};
      tbl[5] = '{1, 32'h1FF, 2'd1, 32'h0,        32'h0000005A};
      tbl[6] = '{1, 32'h0FF, 2'd3, 32'h0,        32'hF00FF000};

      #1;
      chk("reset_busy", {31'd0, busy_o}, 32'd0);
      chk("reset_ram_addr", ram_addr_o, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Fetch of a word from address 4.
      poke(12'd4, 8'h13); poke(12'd5, 8'h05); poke(12'd6, 8'h10); poke(12'd7, 8'h00);
      begin
         logic [31:0] addrs[$];
         int dones = 0, wrs = 0, flat = -1;
         @(negedge clk);
         if_req_i = 1'b1; if_addr_i = 32'h4;
         for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (busy_o && addrs.size() < 4) addrs.push_back(ram_addr_o);
            if (ram_wr_o) wrs++;
            if (if_done_o) begin
               dones++;
               if (flat < 0) flat = k;
               if_req_i = 1'b0;
            end
         end
         chk("if_latency", flat, 6);
         chk("if_done_pulses", dones, 1);
         chk("if_no_write", wrs, 0);
         chk("if_data", if_data_o, 32'h00100513);
         if (addrs.size() == 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("if_addr%0d", i), addrs[i], 32'(4 + i));
         end else begin
            chk("if_addr_count", addrs.size(), 4);
         end
      end

      // Table of stores and sub-word/misaligned loads.
      for (int i = 0; i < 7; i++) begin
         run_txn(tbl[i].kind, tbl[i].addr, tbl[i].len, tbl[i].wd, got, lat, wrcyc);
         n = nbytes(tbl[i].kind, tbl[i].len);
         chk($sformatf("tbl%0d_lat", i), lat, (tbl[i].kind >= 2) ? n + 1 : n + 2);
         if (tbl[i].kind >= 2) chk($sformatf("tbl%0d_wrcyc", i), wrcyc, n);
         else                  chk($sformatf("tbl%0d_data", i), got, tbl[i].exp);
      end
      chk("store_bytes", {ram[12'h100], ram[12'h101], ram[12'h102], ram[12'h103]}, 32'hF00FF00F);

      // Simultaneous fetch and load: MEM first, fetch after with no overlap.
      begin
         int mk = -1, ik = -1, wrs = 0;
         logic busy_at_done = 1'b1;
         @(negedge clk);
         if_req_i = 1'b1; if_addr_i = 32'h4;
         mem_re_i = 1'b1; mem_addr_i = 32'h100; mem_len_i = 2'd2;
         for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (ram_wr_o) wrs++;
            if (mem_done_o && mk < 0) begin mk = k; busy_at_done = busy_o; mem_re_i = 1'b0; end
            if (if_done_o && ik < 0) begin ik = k; if_req_i = 1'b0; end
         end
         chk("arb_mem_latency", mk, 6);
         chk("arb_busy_in_done", {31'd0, busy_at_done}, 32'd0);
         chk("arb_if_gap_ok", {31'd0, (ik - mk == 6) || (ik - mk == 7)}, 32'd1);
         chk("arb_mem_data", mem_rdata_o, 32'h0FF00FF0);
         chk("arb_if_data", if_data_o, 32'h00100513);
         chk("arb_no_write", wrs, 0);
      end

      // Asynchronous reset in the middle of a load.
      @(negedge clk);
      mem_re_i = 1'b1; mem_addr_i = 32'h100; mem_len_i = 2'd2;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
      chk("mid_rst_ram_addr", ram_addr_o, 32'd0);
      chk("mid_rst_if_data", if_data_o, 32'd0);
      chk("mid_rst_mem_data", mem_rdata_o, 32'd0);
      chk("mid_rst_misc", {28'd0, if_done_o, mem_done_o, ram_wr_o, |ram_wdata_o}, 32'd0);
      mem_re_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Reset during the third byte of a word store.
      poke(12'h202, 8'h11); poke(12'h203, 8'h22);
      begin
         int saw = 0;
         @(negedge clk);
         mem_we_i = 1'b1; mem_addr_i = 32'h200; mem_len_i = 2'd2; mem_wdata_i = 32'hAABBCCDD;
         repeat (3) @(negedge clk);
         chk("wr_rst_pre_addr", {ram_addr_o[30:0], ram_wr_o}, {31'h202, 1'b1});
         #2 rst = 1'b1;
         mem_we_i = 1'b0;
         #1;
         chk("wr_rst_wr_drop", {31'd0, ram_wr_o}, 32'd0);
         @(negedge clk);
         rst = 1'b0;
         repeat (4) begin
            @(negedge clk);
            if (mem_done_o) saw++;
         end
         chk("wr_rst_no_done", saw, 0);
         chk("wr_rst_bytes", {ram[12'h200], ram[12'h201], ram[12'h202], ram[12'h203]},
             32'hDDCC1122);
      end

      // Random traffic against a byte-array reference.
      for (int i = 0; i < 4096; i++) sh[i] = ram[i];
      for (int t = 0; t < 40; t++) begin
         int          kind;
         logic [31:0] a, wd;
         logic [1:0]  len;
         kind = $urandom_range(0, 3);
         a    = 32'($urandom_range(0, 4091));
         len  = 2'($urandom_range(0, 3));
         wd   = $urandom;
         n    = nbytes(kind, len);
         run_txn(kind, a, len, wd, got, lat, wrcyc);
         chk($sformatf("rnd%0d_lat", t), lat, (kind >= 2) ? n + 1 : n + 2);
         if (kind >= 2) begin
            for (int b = 0; b < n; b++) sh[a + 32'(b)] = wd[8*b +: 8];
            chk($sformatf("rnd%0d_wrcyc", t), wrcyc, n);
         end else begin
            expd = '0;
            for (int b = 0; b < n; b++) expd = expd | (32'(sh[a + 32'(b)]) << (8 * b));
            chk($sformatf("rnd%0d_data", t), got, expd);
         end
      end
      @(negedge clk);
      begin
         int bad = 0;
         for (int i = 0; i < 4096; i++) if (ram[i] !== sh[i]) bad++;
         chk("rnd_ram_image", bad, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_sched.md
# ram_sched

Sequencer and arbiter for the single byte-wide, synchronous-read RAM port. It sits between the instruction-fetch stage, the MEM stage and the 128 KiB `ram`, and grants the port to one requester at a time. It breaks each byte, halfword or word access into consecutive single-byte RAM cycles. For reads, it assembles the returned bytes little-endian and signals completion with a one-cycle done pulse.

## Interface
- `ADDR_WIDTH`, default 17: width of the RAM address. Kept for documentation; the block drives the full 32-bit address and the top level truncates it.
- `clk` input, 1 bit: system clock. Rising edge only.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `if_req_i` input, 1 bit: fetch request, level-held until `if_done_o`.
- `if_addr_i` input, 32 bits: fetch byte address. Always a 4-byte read.
- `if_done_o` output, 1 bit: one-cycle pulse; `if_data_o` is valid in this cycle.
- `if_data_o` output, 32 bits: fetched word. Held until the next fetch completes.
- `mem_re_i` input, 1 bit: MEM load request, level-held until `mem_done_o`.
- `mem_we_i` input, 1 bit: MEM store request, level-held until `mem_done_o`.
- `mem_addr_i` input, 32 bits: load/store byte address.
- `mem_len_i` input, 2 bits: access size. 0 = byte, 1 = half, 2 = word, 3 = treated as word.
- `mem_wdata_i` input, 32 bits: store data. Byte k is bits [8k+7:8k].
- `mem_done_o` output, 1 bit: one-cycle completion pulse.
- `mem_rdata_o` output, 32 bits: load data, zero-extended. Sign extension is done in MEM.
- `ram_addr_o` output, 32 bits: RAM byte address.
- `ram_wr_o` output, 1 bit: 1 = write, 0 = read. Equals `~r_nw`.
- `ram_wdata_o` output, 8 bits: RAM write byte.
- `ram_rdata_i` input, 8 bits: RAM read byte. Valid one cycle after its address is driven.
- `busy_o` output, 1 bit: high when the state is not IDLE.

## Operation
States:
- **IDLE**
  - Outputs: `ram_wr_o`=0, `ram_addr_o`=0, `ram_wdata_o`=0.
  - Arbitration happens at the rising edge, only in IDLE and only when neither done output is high in that cycle.
  - Priority is fixed: MEM over IF. There is no preemption. IF may wait indefinitely while MEM keeps requesting; this is intended.
  - On a grant, latch the base address, byte count n (1, 2 or 4), store data and owner, and clear `cnt`. Go to RD (MEM load or IF) or WR (MEM store).
  - If both `mem_re_i` and `mem_we_i` are high, the request is a store.
- **RD**
  - Outputs: `ram_addr_o` = base + `cnt`, `ram_wr_o`=0.
  - Each edge: if `cnt`≥1, capture `ram_rdata_i` into byte `cnt`-1 of the assembly register; then increment `cnt`.
  - At the edge where `cnt`==n: capture the last byte, copy the assembled value into the owner's data output, pulse the owner's done, and go to IDLE.
  - Bytes at index n and above are zero.
- **WR**
  - Outputs: `ram_wr_o`=1, `ram_addr_o` = base + `cnt`, `ram_wdata_o` = store byte `cnt`.
  - At the edge where `cnt`==n-1: pulse `mem_done_o` and go to IDLE.
- Addresses are computed as 32-bit base + `cnt`, with modulo-2^32 wrap. Misaligned accesses are legal and handled byte by byte.
- Done outputs are registered and high for exactly the first IDLE cycle after completion. The requester drops its request in that same cycle.
- Data outputs change only when a read completes for their port.

## Timing
- All outputs are 0 and the state is IDLE immediately on `rst`, with no clock needed. Reset mid-operation abandons the access: bytes already written stay written, and no done pulse is produced.
- Read of n bytes: the grant edge is E0, RD occupies n+1 cycles, and done is high in the cycle after E0+n+1. A word read shows done in the 6th cycle after the grant cycle.
- Write of n bytes: WR occupies n cycles, and done is high in the following cycle.
- Back-to-back: the next grant happens at the end of the done cycle, so there is one idle cycle on the RAM port between accesses.
- `busy_o` is 0 in the done cycle.

## Test plan
- **Reset.** Assert `rst` mid-simulation with no clock edge. Required: every output is 0 immediately and `busy_o`=0.
- **IF word read.** RAM[4..7] = 13,05,10,00; `if_req_i` with addr 0x4. Required: `ram_addr_o` = 4, 5, 6, 7 on consecutive cycles, `ram_wr_o` stays 0, a single `if_done_o` pulse, and `if_data_o`=0x00100513.
- **MEM store then load.** SW 0x0FF00FF0 at 0x100. Required: `ram_wr_o`=1 for 4 cycles writing F0, 0F, F0, 0F to 0x100..0x103. Then LW 0x100. Required: `mem_rdata_o`=0x0FF00FF0.
- **Simultaneous requests.** `if_req_i` and `mem_re_i` rise on the same cycle. Required: MEM is granted first, and IF is granted at the end of the `mem_done_o` cycle with no overlapping RAM cycles.
- **Sub-word loads.** After the store above, LB 0x101 and LH 0x101. Required: `mem_rdata_o` = 0x0000000F and 0x0000F00F respectively; LB uses 1 RAM cycle and LH uses 2.
- **Reset during write.** SW 0xAABBCCDD at 0x200, with `rst` asserted during the `cnt`=2 cycle, before its edge. Required: `ram_wr_o` drops immediately, 0x200=DD and 0x201=CC, 0x202 and 0x203 are unchanged, and no `mem_done_o` pulse.
